data_memory_arbiter: RTL and testbench

Two-requester arbiter and access sequencer in front of the single-port DataMemory. It accepts load/store requests from requester 0 (pipeline MEM stage) and requester 1 (loader/debug port), grants one at a time with round-robin fairness, and rejects illegal or misaligned accesses. It drives the DataMemory Address/WriteData/MemWrite/MemRead/ByteSel pins and returns captured ReadData with a one-cycle Done pulse.

---
 rtl/data_memory_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_data_memory_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_arbiter
// Description : Round-robin two-requester arbiter and access sequencer for a
//               single-port DataMemory, with alignment/size legality checks.
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory_arbiter (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        R0Req,
    input  logic        R1Req,
    input  logic        R0Write,
    input  logic        R1Write,
    input  logic [31:0] R0Address,
    input  logic [31:0] R1Address,
    input  logic [31:0] R0WriteData,
    input  logic [31:0] R1WriteData,
    input  logic [1:0]  R0ByteSel,
    input  logic [1:0]  R1ByteSel,
    output logic        R0Grant,
    output logic        R1Grant,
    output logic        R0Done,
    output logic        R1Done,
    output logic        R0Error,
    output logic        R1Error,
    output logic [31:0] R0ReadData,
    output logic [31:0] R1ReadData,
    output logic [31:0] Address,
    output logic [31:0] WriteData,
    output logic        MemWrite,
    output logic        MemRead,
    output logic [1:0]  ByteSel,
    input  logic [31:0] ReadData
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_owner;
    logic        r_last;
    logic        r_err;
    logic        r_write;
    logic [31:0] r_address;
    logic [31:0] r_write_data;
    logic [1:0]  r_byte_sel;
    logic [31:0] r_rd0;
    logic [31:0] r_rd1;

    logic        w_elig0;
    logic        w_elig1;
    logic        w_grant_valid;
    logic        w_grant_id;
    logic        w_sel_write;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic [1:0]  w_sel_bytesel;
    logic        w_sel_illegal;

    // The owner still holds Req during DONE, so it must not win again there.
    assign w_elig0 = R0Req && !((r_state == DONE) && (r_owner == 1'b0));
    assign w_elig1 = R1Req && !((r_state == DONE) && (r_owner == 1'b1));

    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_id    = 1'b0;
        if ((r_state == IDLE) || (r_state == DONE)) begin
            if (w_elig0 && w_elig1) begin
                w_grant_valid = 1'b1;
                w_grant_id    = ~r_last;
            end else if (w_elig0) begin
                w_grant_valid = 1'b1;
                w_grant_id    = 1'b0;
            end else if (w_elig1) begin
                w_grant_valid = 1'b1;
                w_grant_id    = 1'b1;
            end
        end
    end

    assign w_sel_write   = w_grant_id ? R1Write     : R0Write;
    assign w_sel_addr    = w_grant_id ? R1Address   : R0Address;
    assign w_sel_wdata   = w_grant_id ? R1WriteData : R0WriteData;
    assign w_sel_bytesel = w_grant_id ? R1ByteSel   : R0ByteSel;

    always_comb begin
        w_sel_illegal = 1'b0;
        case (w_sel_bytesel)
            2'b00:   w_sel_illegal = (w_sel_addr[1:0] != 2'b00);
            2'b11:   w_sel_illegal = w_sel_addr[0];
            2'b01:   w_sel_illegal = 1'b0;
            default: w_sel_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        R0Grant      = 1'b0;
        R1Grant      = 1'b0;
        R0Done       = 1'b0;
        R1Done       = 1'b0;
        R0Error      = 1'b0;
        R1Error      = 1'b0;
        MemWrite     = 1'b0;
        MemRead      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_valid) begin
                    w_state_next = ACCESS;
                end
            end
            ACCESS: begin
                w_state_next = DONE;
                R0Grant      = (r_owner == 1'b0);
                R1Grant      = (r_owner == 1'b1);
                MemWrite     = !r_err && r_write;
                MemRead      = !r_err && !r_write;
            end
            DONE: begin
                w_state_next = w_grant_valid ? ACCESS : IDLE;
                R0Done       = (r_owner == 1'b0);
                R1Done       = (r_owner == 1'b1);
                R0Error      = (r_owner == 1'b0) && r_err;
                R1Error      = (r_owner == 1'b1) && r_err;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Operands are latched at grant; requesters hold them stable until Done,
    // and the latched copy gives the hold-last-value behaviour outside ACCESS.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_owner      <= 1'b0;
            r_last       <= 1'b1;
            r_err        <= 1'b0;
            r_write      <= 1'b0;
            r_address    <= 32'h0;
            r_write_data <= 32'h0;
            r_byte_sel   <= 2'b00;
            r_rd0        <= 32'h0;
            r_rd1        <= 32'h0;
        end else begin
            if (w_grant_valid) begin
                r_owner      <= w_grant_id;
                r_last       <= w_grant_id;
                r_err        <= w_sel_illegal;
                r_write      <= w_sel_write;
                r_address    <= w_sel_addr;
                r_write_data <= w_sel_wdata;
                r_byte_sel   <= w_sel_bytesel;
            end
            if ((r_state == ACCESS) && !r_err && !r_write) begin
                if (r_owner == 1'b0) begin
                    r_rd0 <= ReadData;
                end else begin
                    r_rd1 <= ReadData;
                end
            end
        end
    end

    assign Address    = r_address;
    assign WriteData  = r_write_data;
    assign ByteSel    = r_byte_sel;
    assign R0ReadData = r_rd0;
    assign R1ReadData = r_rd1;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory_arbiter
// Description : Scoreboard bench for data_memory_arbiter with a DataMemory model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_data_memory_arbiter;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        R0Req, R1Req, R0Write, R1Write;
    logic [31:0] R0Address, R1Address, R0WriteData, R1WriteData;
    logic [1:0]  R0ByteSel, R1ByteSel;
    logic        R0Grant, R1Grant, R0Done, R1Done, R0Error, R1Error;
    logic [31:0] R0ReadData, R1ReadData;
    logic [31:0] Address, WriteData, ReadData;
    logic        MemWrite, MemRead;
    logic [1:0]  ByteSel;

    data_memory_arbiter dut (
        .Clk(Clk), .Rst(Rst),
        .R0Req(R0Req), .R1Req(R1Req),
        .R0Write(R0Write), .R1Write(R1Write),
        .R0Address(R0Address), .R1Address(R1Address),
        .R0WriteData(R0WriteData), .R1WriteData(R1WriteData),
        .R0ByteSel(R0ByteSel), .R1ByteSel(R1ByteSel),
        .R0Grant(R0Grant), .R1Grant(R1Grant),
        .R0Done(R0Done), .R1Done(R1Done),
        .R0Error(R0Error), .R1Error(R1Error),
        .R0ReadData(R0ReadData), .R1ReadData(R1ReadData),
        .Address(Address), .WriteData(WriteData),
        .MemWrite(MemWrite), .MemRead(MemRead),
        .ByteSel(ByteSel), .ReadData(ReadData)
    );

    always #5 Clk = ~Clk;

    // Little-endian DataMemory model: combinational read, write at the edge.
    logic [31:0] mem [0:63];
    logic        mem_init_done = 1'b0;

    always_comb begin
        ReadData = 32'h0;
        case (ByteSel)
            2'b00: ReadData = mem[Address[7:2]];
            2'b11: ReadData = Address[1] ? {16'h0, mem[Address[7:2]][31:16]}
                                         : {16'h0, mem[Address[7:2]][15:0]};
            2'b01: ReadData = {24'h0, mem[Address[7:2]][{Address[1:0], 3'b000} +: 8]};
            default: ReadData = 32'h0;
        endcase
    end

    always @(posedge Clk) begin
        if (Rst && !mem_init_done) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem_init_done <= 1'b1;
        end else if (MemWrite) begin
            case (ByteSel)
                2'b00: mem[Address[7:2]] <= WriteData;
                2'b11: begin
                    if (Address[1]) mem[Address[7:2]][31:16] <= WriteData[15:0];
                    else            mem[Address[7:2]][15:0]  <= WriteData[15:0];
                end
                2'b01: mem[Address[7:2]][{Address[1:0], 3'b000} +: 8] <= WriteData[7:0];
                default: ;
            endcase
        end
    end

    typedef struct packed {
        logic        err;
        logic        chk;
        logic [31:0] rd;
    } done_t;

    typedef struct packed {
        logic        id;
        logic        wr;
        logic        rd;
        logic [31:0] addr;
    } grant_t;

    done_t  q0[$];
    done_t  q1[$];
    grant_t qg[$];
    int     checks = 0;
    int     errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic exp_grant(input logic id, input logic wr, input logic rd, input logic [31:0] addr);
        grant_t g;
        g.id = id; g.wr = wr; g.rd = rd; g.addr = addr;
        qg.push_back(g);
    endtask

    task automatic check_done(input int r);
        done_t e;
        logic  act_err;
        logic [31:0] act_rd;
        act_err = (r == 0) ? R0Error : R1Error;
        act_rd  = (r == 0) ? R0ReadData : R1ReadData;
        checks++;
        if (((r == 0) ? q0.size() : q1.size()) == 0) begin
            errors++;
            $display("FAIL done_r%0d: unexpected Done pulse, got Done=1 expected none", r);
        end else begin
            e = (r == 0) ? q0.pop_front() : q1.pop_front();
            if (act_err !== e.err || (e.chk && act_rd !== e.rd)) begin
                errors++;
                $display("FAIL done_r%0d: got Error=%b ReadData=%h expected Error=%b ReadData=%h",
                         r, act_err, act_rd, e.err, e.chk ? e.rd : act_rd);
            end
        end
    endtask

    always @(negedge Clk) begin
        grant_t g;
        if (R0Grant || R1Grant) begin
            checks++;
            if (qg.size() == 0) begin
                errors++;
                $display("FAIL grant: got Grant=%b%b with no grant expected", R1Grant, R0Grant);
            end else begin
                g = qg.pop_front();
                if ({R1Grant, R0Grant} !== (g.id ? 2'b10 : 2'b01) || MemWrite !== g.wr ||
                    MemRead !== g.rd || Address !== g.addr) begin
                    errors++;
                    $display("FAIL grant: got G1G0=%b%b W=%b R=%b A=%h expected id=%0d W=%b R=%b A=%h",
                             R1Grant, R0Grant, MemWrite, MemRead, Address, g.id, g.wr, g.rd, g.addr);
                end
            end
        end else if (!Rst) begin
            checks++;
            if (MemWrite !== 1'b0 || MemRead !== 1'b0) begin
                errors++;
                $display("FAIL strobe_idle: got MemWrite=%b MemRead=%b expected 0 0", MemWrite, MemRead);
            end
        end
        if (R0Done) check_done(0);
        if (R1Done) check_done(1);
    end

    task automatic do_req(input int r, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [1:0] sel, input logic exp_err, input logic [31:0] exp_rd,
                          input int exp_lat);
        done_t e;
        int    n;
        logic  seen;
        e.err = exp_err;
        e.chk = !wr && !exp_err;
        e.rd  = exp_rd;
        @(posedge Clk);
        #1;
        if (r == 0) begin
            q0.push_back(e);
            R0Write = wr; R0Address = addr; R0WriteData = wd; R0ByteSel = sel; R0Req = 1'b1;
        end else begin
            q1.push_back(e);
            R1Write = wr; R1Address = addr; R1WriteData = wd; R1ByteSel = sel; R1Req = 1'b1;
        end
        n = 0;
        seen = 1'b0;
        while (!seen && n < 30) begin
            @(negedge Clk);
            n++;
            seen = (r == 0) ? R0Done : R1Done;
        end
        if (r == 0) R0Req = 1'b0; else R1Req = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL timeout_r%0d: got no Done in %0d cycles expected Done", r, n);
        end else if (exp_lat != 0) begin
            checks++;
            if (n != exp_lat) begin
                errors++;
                $display("FAIL latency_r%0d: got %0d cycles expected %0d", r, n, exp_lat);
            end
        end
    endtask

    function automatic logic [7:0] byte_pat(input int i);
        return (i == 1 || i == 2) ? 8'hFF : 8'h00;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst = 1'b1;
        R0Req = 0; R1Req = 0; R0Write = 0; R1Write = 0;
        R0Address = 0; R1Address = 0; R0WriteData = 0; R1WriteData = 0;
        R0ByteSel = 0; R1ByteSel = 0;
        repeat (3) @(posedge Clk);
        #1 Rst = 1'b0;
        @(negedge Clk);
        chk("rst_r0rd", R0ReadData, 32'h0);
        chk("rst_r1rd", R1ReadData, 32'h0);
        chk("rst_addr", Address, 32'h0);
        chk("rst_wdata", WriteData, 32'h0);
        chk("rst_ctl", {22'h0, ByteSel, MemWrite, MemRead, R0Grant, R1Grant, R0Done, R1Done, R0Error, R1Error}, 32'h0);

        // First tie after reset: R0 wins, R1 follows directly after R0's DONE.
        exp_grant(0, 0, 1, 32'd4);
        exp_grant(1, 1, 0, 32'd8);
        fork
            do_req(0, 0, 32'd4, 32'h0, 2'b00, 0, 32'h0, 3);
            do_req(1, 1, 32'd8, 32'd44, 2'b00, 0, 32'h0, 5);
        join
        exp_grant(1, 0, 1, 32'd8);
        do_req(1, 0, 32'd8, 32'h0, 2'b00, 0, 32'd44, 3);

        exp_grant(0, 1, 0, 32'd16);
        do_req(0, 1, 32'd16, 32'h12345678, 2'b00, 0, 32'h0, 3);
        exp_grant(0, 0, 1, 32'd16);
        do_req(0, 0, 32'd16, 32'h0, 2'b00, 0, 32'h12345678, 3);

        // R0 was granted last, so the continuous run starts with R1.
        for (int i = 0; i < 4; i++) begin
            exp_grant(1, 0, 1, 32'd8);
            exp_grant(0, 0, 1, 32'd16);
        end
        fork
            begin
                for (int i = 0; i < 4; i++) do_req(0, 0, 32'd16, 32'h0, 2'b00, 0, 32'h12345678, 0);
            end
            begin
                for (int j = 0; j < 4; j++) do_req(1, 0, 32'd8, 32'h0, 2'b00, 0, 32'd44, 0);
            end
        join

        exp_grant(0, 0, 0, 32'd26);
        do_req(0, 1, 32'd26, 32'hDEADBEEF, 2'b00, 1, 32'h0, 3);
        exp_grant(0, 0, 0, 32'd33);
        do_req(0, 0, 32'd33, 32'h0, 2'b11, 1, 32'h0, 3);
        chk("r0rd_hold", R0ReadData, 32'h12345678);
        exp_grant(1, 0, 0, 32'd0);
        do_req(1, 0, 32'd0, 32'h0, 2'b10, 1, 32'h0, 3);
        exp_grant(1, 0, 0, 32'd40);
        do_req(1, 1, 32'd40, 32'hFFFFFFFF, 2'b10, 1, 32'h0, 3);
        chk("r1rd_hold", R1ReadData, 32'd44);
        exp_grant(0, 0, 1, 32'd24);
        do_req(0, 0, 32'd24, 32'h0, 2'b00, 0, 32'h0, 3);
        exp_grant(0, 0, 1, 32'd40);
        do_req(0, 0, 32'd40, 32'h0, 2'b00, 0, 32'h0, 3);

        for (int i = 0; i < 4; i++) begin
            exp_grant(1, 1, 0, 32'd32 + i);
            do_req(1, 1, 32'd32 + i, {24'hA5A5A5, byte_pat(i)}, 2'b01, 0, 32'h0, 3);
        end
        for (int i = 0; i < 4; i++) begin
            exp_grant(1, 0, 1, 32'd32 + i);
            do_req(1, 0, 32'd32 + i, 32'h0, 2'b01, 0, {24'h0, byte_pat(i)}, 3);
        end
        exp_grant(1, 0, 1, 32'd32);
        do_req(1, 0, 32'd32, 32'h0, 2'b00, 0, 32'h00FFFF00, 3);

        exp_grant(0, 1, 0, 32'd24);
        do_req(0, 1, 32'd24, 32'h123400FF, 2'b11, 0, 32'h0, 3);
        exp_grant(0, 1, 0, 32'd26);
        do_req(0, 1, 32'd26, 32'h5678FF00, 2'b11, 0, 32'h0, 3);
        exp_grant(0, 0, 1, 32'd24);
        do_req(0, 0, 32'd24, 32'h0, 2'b11, 0, 32'h000000FF, 3);
        exp_grant(0, 0, 1, 32'd26);
        do_req(0, 0, 32'd26, 32'h0, 2'b11, 0, 32'h0000FF00, 3);
        exp_grant(0, 0, 1, 32'd24);
        do_req(0, 0, 32'd24, 32'h0, 2'b00, 0, 32'hFF0000FF, 3);

        // Reset lands on the edge that closes R1's store ACCESS cycle.
        exp_grant(1, 1, 0, 32'd12);
        @(posedge Clk);
        #1;
        R1Write = 1'b1; R1Address = 32'd12; R1WriteData = 32'hCAFEF00D; R1ByteSel = 2'b00; R1Req = 1'b1;
        @(posedge Clk);
        #1 Rst = 1'b1;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        R1Req = 1'b0;
        @(negedge Clk);
        chk("rst2_done", {30'h0, R1Done, R0Done}, 32'h0);
        chk("rst2_grant", {29'h0, R1Grant, R0Grant, MemWrite}, 32'h0);
        chk("rst2_r1rd", R1ReadData, 32'h0);
        chk("rst2_addr", Address, 32'h0);

        exp_grant(0, 0, 1, 32'd12);
        exp_grant(1, 0, 1, 32'd8);
        fork
            do_req(0, 0, 32'd12, 32'h0, 2'b00, 0, 32'hCAFEF00D, 3);
            do_req(1, 0, 32'd8, 32'h0, 2'b00, 0, 32'd44, 5);
        join

        repeat (4) @(posedge Clk);
        chk("pending", q0.size() + q1.size() + qg.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
